// File: rtl/fsic_phase_pkg.sv
// Shared types and sizing helpers for the coreclk phase-lock monitor.
package fsic_phase_pkg;

   // Per-channel monitor state
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAcq    = 2'd1,
      StLocked = 2'd2
   } ph_state_e;

   // Width of a phase count for a given ioclk:coreclk ratio (ratio >= 2)
   function automatic int unsigned phase_w(input int unsigned ratio);
      return $clog2(ratio);
   endfunction

   // Width of a counter that must reach n-1 (at least one bit)
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fsic_phase_lock_ch.sv
// One monitored channel: input sample register, lock FSM, run/miss counters,
// slip pulse and saturating slip counter.
module fsic_phase_lock_ch
   import fsic_phase_pkg::*;
#(
   parameter int unsigned pCLK_RATIO = 4,
   parameter int unsigned pLOCK_CNT  = 8,
   parameter int unsigned pLOSS_CNT  = 3,
   parameter int unsigned pERR_W     = 8,
   parameter int unsigned PW         = phase_w(pCLK_RATIO)
) (
   input  logic              coreclk,
   input  logic              axis_rst_n,
   input  logic              enable,
   input  logic              clr_err,
   input  logic [PW-1:0]     phase_in,
   output logic              locked,
   output logic [PW-1:0]     lock_phase,
   output logic              slip,
   output logic [pERR_W-1:0] err_cnt
);

   localparam int unsigned       CW       = cnt_w(pLOCK_CNT);
   localparam int unsigned       MW       = cnt_w(pLOSS_CNT);
   localparam logic [CW-1:0]     LockLast = CW'(pLOCK_CNT - 1);
   localparam logic [MW-1:0]     LossLast = MW'(pLOSS_CNT - 1);
   localparam logic [pERR_W-1:0] ErrMax   = '1;

   ph_state_e         state_q;
   logic [PW-1:0]     sample_q;
   logic [PW-1:0]     cand_q;
   logic [PW-1:0]     lock_phase_q;
   logic [CW-1:0]     cnt_q;
   logic [MW-1:0]     miss_q;
   logic              locked_q;
   logic              slip_q;
   logic [pERR_W-1:0] err_q;

   logic [2**PW-1:0]  valid_lut;
   logic              valid;
   logic              bad;
   logic              loss;

   // Codes at or above the ratio can appear when PW rounds up; they are never valid
   always_comb begin
      valid_lut = '0;
      for (int unsigned i = 0; i < 2**PW; i++) begin
         valid_lut[i] = (i < pCLK_RATIO);
      end
   end

   assign valid = valid_lut[sample_q];
   assign bad   = !valid || (sample_q != lock_phase_q);
   assign loss  = enable && (state_q == StLocked) && bad && (miss_q == LossLast);

   // Sample register plus lock FSM; all outputs registered here
   always_ff @(posedge coreclk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q      <= StIdle;
         sample_q     <= '0;
         cand_q       <= '0;
         lock_phase_q <= '0;
         cnt_q        <= '0;
         miss_q       <= '0;
         locked_q     <= 1'b0;
         slip_q       <= 1'b0;
      end else begin
         sample_q <= phase_in;
         slip_q   <= 1'b0;
         if (!enable) begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            miss_q   <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  cnt_q   <= '0;
                  miss_q  <= '0;
                  state_q <= StAcq;
               end
               StAcq: begin
                  if (!valid) begin
                     cnt_q <= '0;
                  end else if (sample_q == cand_q) begin
                     if (cnt_q == LockLast) begin
                        state_q      <= StLocked;
                        locked_q     <= 1'b1;
                        lock_phase_q <= cand_q;
                        miss_q       <= '0;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end else begin
                     cand_q <= sample_q;
                     cnt_q  <= CW'(1);
                  end
               end
               StLocked: begin
                  if (!bad) begin
                     miss_q <= '0;
                  end else if (miss_q == LossLast) begin
                     // The failing sample seeds the next acquisition
                     state_q  <= StAcq;
                     locked_q <= 1'b0;
                     slip_q   <= 1'b1;
                     cand_q   <= sample_q;
                     cnt_q    <= valid ? CW'(1) : '0;
                  end else begin
                     miss_q <= miss_q + MW'(1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Saturating slip count; a clear coinciding with a slip still counts that slip
   always_ff @(posedge coreclk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         err_q <= '0;
      end else if (clr_err) begin
         err_q <= loss ? pERR_W'(1) : '0;
      end else if (loss && (err_q != ErrMax)) begin
         err_q <= err_q + pERR_W'(1);
      end
   end

   assign locked     = locked_q;
   assign lock_phase = lock_phase_q;
   assign slip       = slip_q;
   assign err_cnt    = err_q;

endmodule

// File: rtl/fsic_coreclk_phase_lock_mon.sv
// Multi-channel coreclk phase-lock monitor: per-channel lock tracking plus
// registered all-locked and cross-lane skew flags.
module fsic_coreclk_phase_lock_mon
   import fsic_phase_pkg::*;
#(
   parameter int unsigned pCLK_RATIO = 4,
   parameter int unsigned pNUM_CH    = 2,
   parameter int unsigned pLOCK_CNT  = 8,
   parameter int unsigned pLOSS_CNT  = 3,
   parameter int unsigned pERR_W     = 8,
   localparam int unsigned PW        = phase_w(pCLK_RATIO)
) (
   input  logic                      coreclk,
   input  logic                      axis_rst_n,
   input  logic                      enable,
   input  logic                      clr_err,
   input  logic [pNUM_CH*PW-1:0]     phase_in,
   output logic [pNUM_CH-1:0]        locked,
   output logic [pNUM_CH*PW-1:0]     lock_phase,
   output logic [pNUM_CH-1:0]        slip,
   output logic [pNUM_CH*pERR_W-1:0] err_cnt,
   output logic                      all_locked,
   output logic                      skew_err
);

   logic all_locked_q;
   logic skew_err_q;
   logic any_skew;

   for (genvar k = 0; k < pNUM_CH; k++) begin : g_ch
      fsic_phase_lock_ch #(
         .pCLK_RATIO (pCLK_RATIO),
         .pLOCK_CNT  (pLOCK_CNT),
         .pLOSS_CNT  (pLOSS_CNT),
         .pERR_W     (pERR_W),
         .PW         (PW)
      ) u_ch (
         .coreclk    (coreclk),
         .axis_rst_n (axis_rst_n),
         .enable     (enable),
         .clr_err    (clr_err),
         .phase_in   (phase_in[k*PW +: PW]),
         .locked     (locked[k]),
         .lock_phase (lock_phase[k*PW +: PW]),
         .slip       (slip[k]),
         .err_cnt    (err_cnt[k*pERR_W +: pERR_W])
      );
   end

   // Any lane captured at a different phase than lane 0 (empty loop for one lane)
   always_comb begin
      any_skew = 1'b0;
      for (int unsigned k = 1; k < pNUM_CH; k++) begin
         if (lock_phase[k*PW +: PW] != lock_phase[PW-1:0]) begin
            any_skew = 1'b1;
         end
      end
   end

   // Aggregate flags, one cycle behind the per-channel registers
   always_ff @(posedge coreclk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         all_locked_q <= 1'b0;
         skew_err_q   <= 1'b0;
      end else begin
         all_locked_q <= &locked;
         skew_err_q   <= (&locked) && any_skew;
      end
   end

   assign all_locked = all_locked_q;
   assign skew_err   = skew_err_q;

endmodule

// File: tb/tb_fsic_coreclk_phase_lock_mon.sv
// Directed bench: default instance (ratio 4, 8-bit counts) and a second
// instance with ratio 3 and 2-bit counts for invalid codes and saturation.
module tb_fsic_coreclk_phase_lock_mon;

   logic       coreclk = 1'b0;
   logic       axis_rst_n;

   // Default instance
   logic       enable, clr_err;
   logic [3:0] phase_in;
   logic [1:0] locked, slip;
   logic [3:0] lock_phase;
   logic [15:0] err_cnt;
   logic       all_locked, skew_err;

   // Ratio 3, 2-bit error counters
   logic       enable2, clr_err2;
   logic [3:0] phase_in2;
   logic [1:0] locked2, slip2;
   logic [3:0] lock_phase2;
   logic [3:0] err_cnt2;
   logic       all_locked2, skew_err2;

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] slip_acc;

   always #5 coreclk = ~coreclk;

   fsic_coreclk_phase_lock_mon #(
      .pCLK_RATIO (4),
      .pNUM_CH    (2),
      .pLOCK_CNT  (8),
      .pLOSS_CNT  (3),
      .pERR_W     (8)
   ) dut (
      .coreclk    (coreclk),
      .axis_rst_n (axis_rst_n),
      .enable     (enable),
      .clr_err    (clr_err),
      .phase_in   (phase_in),
      .locked     (locked),
      .lock_phase (lock_phase),
      .slip       (slip),
      .err_cnt    (err_cnt),
      .all_locked (all_locked),
      .skew_err   (skew_err)
   );

   fsic_coreclk_phase_lock_mon #(
      .pCLK_RATIO (3),
      .pNUM_CH    (2),
      .pLOCK_CNT  (8),
      .pLOSS_CNT  (3),
      .pERR_W     (2)
   ) dut2 (
      .coreclk    (coreclk),
      .axis_rst_n (axis_rst_n),
      .enable     (enable2),
      .clr_err    (clr_err2),
      .phase_in   (phase_in2),
      .locked     (locked2),
      .lock_phase (lock_phase2),
      .slip       (slip2),
      .err_cnt    (err_cnt2),
      .all_locked (all_locked2),
      .skew_err   (skew_err2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n edges, sampling 1 time unit after each; remembers any slip seen
   task automatic step(input int n);
      repeat (n) begin
         @(posedge coreclk);
         #1;
         slip_acc = slip_acc | slip;
      end
   endtask

   initial begin
      axis_rst_n = 1'b0;
      enable     = 1'b0;
      clr_err    = 1'b0;
      phase_in   = 4'h0;
      enable2    = 1'b0;
      clr_err2   = 1'b0;
      phase_in2  = 4'h0;
      slip_acc   = 2'b00;

      // Reset state
      step(2);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_lock_phase", 32'(lock_phase), 32'h0);
      check("rst_err", 32'(err_cnt), 32'h0);
      check("rst_aggr", 32'({all_locked, skew_err, slip}), 32'h0);
      axis_rst_n = 1'b1;
      step(1);

      // 1: both lanes at phase 2, lock after E9, all_locked after E10
      enable   = 1'b1;
      phase_in = 4'b1010;
      step(8);
      check("t1_not_yet", 32'(locked), 32'h0);
      step(1);
      check("t1_locked", 32'(locked), 32'h3);
      check("t1_phase", 32'(lock_phase), 32'hA);
      check("t1_all_early", 32'(all_locked), 32'h0);
      step(1);
      check("t1_all", 32'(all_locked), 32'h1);
      check("t1_skew", 32'(skew_err), 32'h0);

      // 2: two bad samples tolerated
      slip_acc = 2'b00;
      phase_in[1:0] = 2'd3;
      step(2);
      phase_in[1:0] = 2'd2;
      step(3);
      check("t2_hold_locked", 32'(locked), 32'h3);
      check("t2_no_slip", 32'(slip_acc), 32'h0);
      check("t2_no_err", 32'(err_cnt), 32'h0);

      // 2: three bad samples drop ch0, then relock at 3
      phase_in[1:0] = 2'd3;
      step(3);
      check("t2_pre_slip", 32'({locked, slip}), 32'hC);
      step(1);
      check("t2_slip", 32'(slip), 32'h1);
      check("t2_unlocked", 32'(locked), 32'h2);
      check("t2_err1", 32'(err_cnt), 32'h0001);
      step(1);
      check("t2_slip_1cyc", 32'(slip), 32'h0);
      check("t2_all_drop", 32'(all_locked), 32'h0);
      step(5);
      check("t2_relock_early", 32'(locked), 32'h2);
      step(1);
      check("t2_relock", 32'(locked), 32'h3);
      check("t2_relock_phase", 32'(lock_phase), 32'hB);
      step(1);
      check("t2_skew", 32'({all_locked, skew_err}), 32'h3);

      // 6a: disable while locked
      slip_acc = 2'b00;
      enable   = 1'b0;
      step(1);
      check("t6_dis_locked", 32'(locked), 32'h0);
      check("t6_dis_slip", 32'(slip_acc), 32'h0);
      check("t6_dis_err", 32'(err_cnt), 32'h0001);
      check("t6_dis_phase", 32'(lock_phase), 32'hB);

      // 3: ch0 locks at 1, ch1 later at 3
      enable   = 1'b1;
      phase_in = 4'b1101;
      step(3);
      phase_in[3:2] = 2'd2;
      step(1);
      phase_in[3:2] = 2'd3;
      step(5);
      check("t3_ch0", 32'(locked), 32'h1);
      check("t3_all0", 32'(all_locked), 32'h0);
      step(3);
      check("t3_ch0_only", 32'(locked), 32'h1);
      step(1);
      check("t3_both", 32'(locked), 32'h3);
      check("t3_flags_lag", 32'({all_locked, skew_err}), 32'h0);
      step(1);
      check("t3_flags", 32'({all_locked, skew_err}), 32'h3);
      check("t3_phase", 32'(lock_phase), 32'hD);

      // 4: ratio 3, invalid code 3 alternating with 0 never locks
      enable2   = 1'b1;
      phase_in2 = 4'b1100;
      for (int i = 0; i < 20; i++) begin
         phase_in2[1:0] = (i % 2 == 1) ? 2'd3 : 2'd0;
         step(1);
      end
      check("t4_never", 32'(locked2), 32'h0);

      // 5: five losses saturate the 2-bit counter
      phase_in2[1:0] = 2'd0;
      step(12);
      check("t5_lock", 32'(locked2), 32'h1);
      for (int i = 0; i < 5; i++) begin
         phase_in2[1:0] = 2'd3;
         step(4);
         check("t5_slip", 32'(slip2), 32'h1);
         phase_in2[1:0] = 2'd0;
         step(10);
         check("t5_relock", 32'(locked2), 32'h1);
         if (i == 2) check("t5_err3", 32'(err_cnt2), 32'h3);
      end
      check("t5_sat", 32'(err_cnt2), 32'h3);

      // 5: clear on the slip edge counts that slip; clear alone zeroes
      phase_in2[1:0] = 2'd3;
      step(3);
      clr_err2 = 1'b1;
      step(1);
      clr_err2 = 1'b0;
      check("t5_clr_slip", 32'({slip2[0], err_cnt2}), 32'h11);
      phase_in2[1:0] = 2'd0;
      step(10);
      clr_err2 = 1'b1;
      step(1);
      clr_err2 = 1'b0;
      check("t5_clr", 32'({locked2[0], err_cnt2}), 32'h10);

      // 6b: async reset while ch0 is re-acquiring
      phase_in[1:0] = 2'd0;
      step(4);
      check("t6_slip2", 32'(err_cnt), 32'h0002);
      step(2);
      #3;
      axis_rst_n = 1'b0;
      #1;
      check("t6_rst_locked", 32'(locked), 32'h0);
      check("t6_rst_phase", 32'(lock_phase), 32'h0);
      check("t6_rst_err", 32'(err_cnt), 32'h0);
      check("t6_rst_aggr", 32'({all_locked, skew_err, slip}), 32'h0);
      check("t6_rst_dut2", 32'({locked2, err_cnt2}), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
